// File: rtl/nco_phase_ctrl.sv
// NCO phase controller: loads a waveform table into an external dual-port RAM, then steps a
// phase accumulator to read it back as a sample stream.
module nco_phase_ctrl #(
   parameter int unsigned PHASE_W    = 24,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_start,
   input  logic                  ld_valid,
   input  logic [DATA_WIDTH-1:0] ld_data,
   output logic                  ld_ready,
   output logic                  table_ok,
   input  logic                  run_en,
   input  logic [PHASE_W-1:0]    fcw,
   input  logic [ADDR_WIDTH-1:0] phase_off,
   output logic                  csb0,
   output logic [ADDR_WIDTH-1:0] addr0,
   output logic [DATA_WIDTH-1:0] din0,
   output logic                  csb1,
   output logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] dout1,
   output logic [DATA_WIDTH-1:0] sample,
   output logic                  sample_valid
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   localparam logic [ADDR_WIDTH-1:0] ONE_A = 1;

   logic [1:0]            r_state, w_state_d;
   logic [PHASE_W-1:0]    r_acc, w_acc_d;
   logic [ADDR_WIDTH-1:0] r_wcnt, w_wcnt_d;
   logic                  r_table_ok, w_table_ok_d;
   logic                  r_ld_ready, w_ld_ready_d;
   logic                  r_csb0, w_csb0_d;
   logic [ADDR_WIDTH-1:0] r_addr0, w_addr0_d;
   logic [DATA_WIDTH-1:0] r_din0, w_din0_d;
   logic                  r_csb1, w_csb1_d;
   logic [ADDR_WIDTH-1:0] r_addr1, w_addr1_d;
   logic                  r_rd_vld;
   logic [DATA_WIDTH-1:0] r_sample;
   logic                  r_sample_valid;

   logic                  w_xfer;
   logic [PHASE_W-1:0]    w_acc_next;
   logic [ADDR_WIDTH-1:0] w_rd_idx;

   assign w_xfer     = ld_valid & r_ld_ready;
   assign w_acc_next = r_acc + fcw;
   assign w_rd_idx   = w_acc_next[PHASE_W-1 -: ADDR_WIDTH] + phase_off;

   always_comb begin
      w_state_d    = r_state;
      w_acc_d      = r_acc;
      w_wcnt_d     = r_wcnt;
      w_table_ok_d = r_table_ok;
      w_ld_ready_d = r_ld_ready;
      w_csb0_d     = 1'b1;
      w_addr0_d    = r_addr0;
      w_din0_d     = r_din0;
      w_csb1_d     = 1'b1;
      w_addr1_d    = r_addr1;

      case (r_state)
         ST_IDLE: begin
            // A reload request wins over starting generation.
            if (load_start) begin
               w_state_d    = ST_LOAD;
               w_wcnt_d     = '0;
               w_table_ok_d = 1'b0;
               w_ld_ready_d = 1'b1;
            end else if (run_en && r_table_ok) begin
               w_state_d = ST_RUN;
            end
         end
         ST_LOAD: begin
            if (w_xfer) begin
               w_csb0_d  = 1'b0;
               w_addr0_d = r_wcnt;
               w_din0_d  = ld_data;
               w_wcnt_d  = r_wcnt + ONE_A;
               if (r_wcnt == '1) begin
                  w_state_d    = ST_IDLE;
                  w_table_ok_d = 1'b1;
                  w_ld_ready_d = 1'b0;
               end
            end
         end
         ST_RUN: begin
            if (!run_en || load_start) begin
               w_state_d = ST_IDLE;
            end else begin
               w_acc_d   = w_acc_next;
               w_addr1_d = w_rd_idx;
               w_csb1_d  = 1'b0;
            end
         end
         default: begin
            w_state_d    = ST_IDLE;
            w_ld_ready_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_acc      <= '0;
         r_wcnt     <= '0;
         r_table_ok <= 1'b0;
         r_ld_ready <= 1'b0;
         r_csb0     <= 1'b1;
         r_addr0    <= '0;
         r_din0     <= '0;
         r_csb1     <= 1'b1;
         r_addr1    <= '0;
      end else begin
         r_state    <= w_state_d;
         r_acc      <= w_acc_d;
         r_wcnt     <= w_wcnt_d;
         r_table_ok <= w_table_ok_d;
         r_ld_ready <= w_ld_ready_d;
         r_csb0     <= w_csb0_d;
         r_addr0    <= w_addr0_d;
         r_din0     <= w_din0_d;
         r_csb1     <= w_csb1_d;
         r_addr1    <= w_addr1_d;
      end
   end

   // Stage 1 tracks the RAM's read edge, stage 2 captures dout1 once it has settled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_vld       <= 1'b0;
         r_sample_valid <= 1'b0;
         r_sample       <= '0;
      end else begin
         r_rd_vld       <= ~r_csb1;
         r_sample_valid <= r_rd_vld;
         if (r_rd_vld) begin
            r_sample <= dout1;
         end
      end
   end

   assign ld_ready     = r_ld_ready;
   assign table_ok     = r_table_ok;
   assign csb0         = r_csb0;
   assign addr0        = r_addr0;
   assign din0         = r_din0;
   assign csb1         = r_csb1;
   assign addr1        = r_addr1;
   assign sample       = r_sample;
   assign sample_valid = r_sample_valid;

endmodule

// File: tb/tb_nco_phase_ctrl.sv
// Bench for nco_phase_ctrl: behavioural dual-port RAM plus queue-based scoreboard on the
// write port, read-address port and sample output.
module tb_nco_phase_ctrl;

   localparam int PW = 24;
   localparam int AW = 8;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          load_start;
   logic          ld_valid;
   logic [DW-1:0] ld_data;
   logic          ld_ready;
   logic          table_ok;
   logic          run_en;
   logic [PW-1:0] fcw;
   logic [AW-1:0] phase_off;
   logic          csb0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] din0;
   logic          csb1;
   logic [AW-1:0] addr1;
   logic [DW-1:0] dout1;
   logic [DW-1:0] sample;
   logic          sample_valid;

   always #5 clk = ~clk;

   nco_phase_ctrl #(
      .PHASE_W   (PW),
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_start  (load_start),
      .ld_valid    (ld_valid),
      .ld_data     (ld_data),
      .ld_ready    (ld_ready),
      .table_ok    (table_ok),
      .run_en      (run_en),
      .fcw         (fcw),
      .phase_off   (phase_off),
      .csb0        (csb0),
      .addr0       (addr0),
      .din0        (din0),
      .csb1        (csb1),
      .addr1       (addr1),
      .dout1       (dout1),
      .sample      (sample),
      .sample_valid(sample_valid)
   );

   // RAM model: latches the read address on the edge, data settles after the negedge.
   logic [DW-1:0] mem [256];
   logic [AW-1:0] rd_q = '0;
   always @(posedge clk) begin
      if (csb0 === 1'b0) mem[addr0] <= din0;
      if (csb1 === 1'b0) rd_q <= addr1;
   end
   always @(negedge clk) dout1 <= mem[rd_q];

   logic [AW+DW-1:0] q_wr  [$];
   logic [AW-1:0]    q_rd  [$];
   logic [DW-1:0]    q_smp [$];
   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;
   int t_rd    = -1;
   int t_sv    = -1;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Monitor: pops an expectation whenever the DUT presents a write, a read or a sample.
   always @(negedge clk) begin
      logic [AW+DW-1:0] e;
      chk("csb_excl", {63'd0, (csb0 === 1'b0) && (csb1 === 1'b0)}, 64'd0);
      if (csb0 === 1'b0) begin
         if (q_wr.size() == 0) chk("wr_unexpected", 64'd1, 64'd0);
         else begin
            e = q_wr.pop_front();
            chk("wr_addr", 64'(addr0), 64'(e[AW+DW-1:DW]));
            chk("wr_data", 64'(din0), 64'(e[DW-1:0]));
         end
      end
      if (csb1 === 1'b0) begin
         if (t_rd < 0) t_rd = cyc;
         if (q_rd.size() == 0) chk("rd_unexpected", 64'd1, 64'd0);
         else chk("rd_addr", 64'(addr1), 64'(q_rd.pop_front()));
      end
      if (sample_valid === 1'b1) begin
         if (t_sv < 0) t_sv = cyc;
         if (q_smp.size() == 0) chk("smp_unexpected", 64'd1, 64'd0);
         else chk("sample", 64'(sample), 64'(q_smp.pop_front()));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check_reset(input string tag);
      chk({tag, "_csb0"}, 64'(csb0), 64'd1);
      chk({tag, "_csb1"}, 64'(csb1), 64'd1);
      chk({tag, "_addr0"}, 64'(addr0), 64'd0);
      chk({tag, "_din0"}, 64'(din0), 64'd0);
      chk({tag, "_addr1"}, 64'(addr1), 64'd0);
      chk({tag, "_sample"}, 64'(sample), 64'd0);
      chk({tag, "_svalid"}, 64'(sample_valid), 64'd0);
      chk({tag, "_table_ok"}, 64'(table_ok), 64'd0);
      chk({tag, "_ld_ready"}, 64'(ld_ready), 64'd0);
   endtask

   // mode 0: data=i*3, ld_valid held; mode 1: data=i, ld_valid toggling. Stops early at stop.
   task automatic load_table(input int mode, input int stop);
      int i = 0;
      int c = 0;
      @(negedge clk);
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      chk("ld_ready_on", 64'(ld_ready), 64'd1);
      chk("table_ok_clr", 64'(table_ok), 64'd0);
      while (i < stop && c < 2000) begin
         ld_valid = (mode == 1) ? (c % 2 == 0) : 1'b1;
         ld_data  = (mode == 0) ? DW'(i * 3) : DW'(i);
         if (ld_valid && ld_ready) begin
            q_wr.push_back({AW'(i), ld_data});
            i++;
         end
         c++;
         @(negedge clk);
      end
      if (stop == 256) begin
         ld_valid = 1'b0;
         chk("load_cycles", 64'(c), (mode == 1) ? 64'd511 : 64'd256);
         @(negedge clk);
         chk("table_ok_set", 64'(table_ok), 64'd1);
         chk("ld_ready_off", 64'(ld_ready), 64'd0);
      end
   endtask

   // Hold run_en for n accumulate cycles, then verify the stop and the 2-sample drain.
   task automatic run_burst(input logic [PW-1:0] f, input logic [AW-1:0] off, input int n,
                            input logic [DW-1:0] last);
      int pulses = 0;
      @(negedge clk);
      fcw       = f;
      phase_off = off;
      run_en    = 1'b1;
      repeat (n + 1) @(negedge clk);
      run_en = 1'b0;
      @(negedge clk);
      chk("csb1_stop", 64'(csb1), 64'd1);
      repeat (5) begin
         if (sample_valid === 1'b1) pulses++;
         @(negedge clk);
      end
      chk("drain_pulses", 64'(pulses), 64'd2);
      chk("sample_frozen", 64'(sample), 64'(last));
      chk("svalid_low", 64'(sample_valid), 64'd0);
   endtask

   logic [AW-1:0] wrap_seq [6];

   initial begin
      rst_n      = 1'b0;
      load_start = 1'b0;
      ld_valid   = 1'b0;
      ld_data    = '0;
      run_en     = 1'b0;
      fcw        = '0;
      phase_off  = '0;
      repeat (2) @(negedge clk);
      check_reset("rst");
      rst_n = 1'b1;
      @(negedge clk);

      load_table(0, 256);
      load_table(1, 256);

      for (int k = 1; k <= 10; k++) begin
         q_rd.push_back(AW'(k));
         q_smp.push_back(DW'(k));
      end
      t_rd = -1;
      t_sv = -1;
      run_burst(24'h010000, 8'h00, 10, 16'd10);
      chk("sv_latency", 64'(t_sv - t_rd), 64'd2);

      // Abort a load at write 100 with ld_valid still high.
      load_table(0, 100);
      #2 rst_n = 1'b0;
      #1 check_reset("abort");
      ld_valid = 1'b0;
      run_en   = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("no_run_csb1", 64'(csb1), 64'd1);
         chk("no_run_table_ok", 64'(table_ok), 64'd0);
      end
      run_en = 1'b0;

      load_table(1, 256);
      wrap_seq = '{8'hFE, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h01};
      for (int k = 0; k < 6; k++) begin
         q_rd.push_back(wrap_seq[k]);
         q_smp.push_back(DW'(wrap_seq[k]));
      end
      run_burst(24'h008000, 8'hFE, 6, 16'h0001);

      repeat (3) @(negedge clk);
      chk("q_wr_empty", 64'(q_wr.size()), 64'd0);
      chk("q_rd_empty", 64'(q_rd.size()), 64'd0);
      chk("q_smp_empty", 64'(q_smp.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/nco_phase_ctrl.md
NCO_PHASE_CTRL -- requirements
Module: nco_phase_ctrl

Interface
REQ-001 SHALL have parameter PHASE_W, default 24, phase accumulator width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, table address width (256 entries).
REQ-003 SHALL have parameter DATA_WIDTH, default 16, sample width.
REQ-004 SHALL have port clk  input  1  single clock; the RAM's clk0 and clk1 are tied to it externally.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port load_start  input  1  one-cycle request to (re)load the table.
REQ-007 SHALL have port ld_valid  input  1  load word valid.
REQ-008 SHALL have port ld_data  input  DATA_WIDTH  load word.
REQ-009 SHALL have port ld_ready  output  1  block accepts a load word.
REQ-010 SHALL have port table_ok  output  1  a complete table has been written.
REQ-011 SHALL have port run_en  input  1  level: generate samples.
REQ-012 SHALL have port fcw  input  PHASE_W  frequency control word.
REQ-013 SHALL have port phase_off  input  ADDR_WIDTH  phase offset added to the table address.
REQ-014 SHALL have ports csb0  output  1, addr0  output  ADDR_WIDTH, din0  output  DATA_WIDTH  RAM write port, csb0 active low.
REQ-015 SHALL have ports csb1  output  1, addr1  output  ADDR_WIDTH  RAM read port; dout1  input  DATA_WIDTH  RAM read data.
REQ-016 SHALL have ports sample  output  DATA_WIDTH and sample_valid  output  1  NCO output.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, RUN; every RAM-facing output SHALL be a register.
REQ-018 IDLE: load_start=1 -> LOAD, write counter wcnt:=0, table_ok:=0; else run_en=1 and table_ok=1 -> RUN; load_start takes priority over run_en.
REQ-019 LOAD: ld_ready=1; a transfer is ld_valid & ld_ready; on each transfer, at the next edge csb0=0, addr0=wcnt, din0=ld_data, and wcnt increments; with no transfer, csb0=1.
REQ-020 LOAD: the transfer with wcnt=255 -> IDLE, table_ok:=1, ld_ready=0 from the next cycle; load_start and run_en ignored in LOAD.
REQ-021 RUN: each cycle acc := acc + fcw mod 2^PHASE_W; addr1 := (acc_next[PHASE_W-1 -: ADDR_WIDTH] + phase_off) mod 256; csb1 := 0.
REQ-022 Read pipeline: RAM samples addr1 at edge t+1, dout1 settles after the negedge; the block registers sample := dout1 at edge t+2, i.e. 2 cycles after addr1 is updated; sample_valid follows the csb1=0 term through the same 2-stage delay.
REQ-023 RUN with run_en=0 or load_start=1 -> IDLE, csb1:=1, acc held; in-flight reads still complete and raise sample_valid (drain, at most 2 cycles).
REQ-024 sample holds its last value when sample_valid=0; acc and address additions wrap silently.
REQ-025 fcw and phase_off SHALL be sampled every RUN cycle; changes take effect on the next accumulate.
REQ-026 csb0 and csb1 SHALL never both be 0 in the same cycle.

Reset
REQ-027 rst_n=0 SHALL asynchronously set: state IDLE, acc=0, wcnt=0, table_ok=0, ld_ready=0, csb0=1, csb1=1, addr0=0, din0=0, addr1=0, sample=0, sample_valid=0 and the valid pipeline cleared.
REQ-028 Reset mid-LOAD SHALL discard the partial load (table_ok=0); reset mid-RUN SHALL drop in-flight samples.

Verification
REQ-029 Load 256 words ld_data=i*3 with ld_valid held high -> 256 consecutive csb0=0 writes, addr0=0..255, table_ok=1 one cycle after the last write.
REQ-030 Load with ld_valid toggling 1/0 -> writes occur only on handshake cycles, addresses contiguous, no dropped or duplicated words.
REQ-031 Table mem[i]=i, fcw=0x010000, phase_off=0, run_en=1 -> addr1=1,2,3,...; sample=1,2,3,... with sample_valid rising 2 cycles after the first addr1.
REQ-032 fcw=0x008000, phase_off=0xFE -> addr1 sequence FE,FF,FF,00,00,01; wrap correct.
REQ-033 run_en dropped after 10 RUN cycles -> csb1=1 next cycle, exactly 2 further sample_valid pulses, then sample frozen.
REQ-034 rst_n asserted at write 100 of a load -> all outputs at reset values immediately, table_ok=0, run_en=1 does not enter RUN.
